aes_enc_arbiter: RTL and testbench

AES_ENC_ARBITER -- requirements
Module: aes_enc_arbiter

---
 rtl/aes_ctrl_pkg.sv | 18 +
 rtl/aes_rr_arb2.sv | 38 +++
 rtl/aes_enc_arbiter.sv | 126 ++++++++++++
 tb/tb_aes_enc_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// rtl/aes_ctrl_pkg.sv - shared encodings and widths for the AES encipher arbiter
package aes_ctrl_pkg;

  localparam int NUM_REQ = 2;
  localparam int BLOCK_W = 128;

  typedef logic [BLOCK_W-1:0] block_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_KEY_START = 3'd1,
    ST_KEY_WAIT  = 3'd2,
    ST_ENC_START = 3'd3,
    ST_ENC_WAIT  = 3'd4,
    ST_RESP      = 3'd5
  } state_t;

endpackage

// File: rtl/aes_rr_arb2.sv
// rtl/aes_rr_arb2.sv - two-input round-robin grant with registered last winner
module aes_rr_arb2
  import aes_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_idx
);

  logic last_grant;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    grant_idx = 1'b0;
    case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = 1'b0;
    endcase
    grant = '0;
    if (req != '0) begin
      grant[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/aes_enc_arbiter.sv
// rtl/aes_enc_arbiter.sv - shares one AES encipher core and key memory between two requesters
module aes_enc_arbiter
  import aes_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         key_init_req,
  input  logic         keylen,
  output logic         key_init_ack,
  output logic         key_loaded,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_block,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_block,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [127:0] rsp0_block,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [127:0] rsp1_block,
  output logic         core_init,
  output logic         core_next,
  output logic         core_keylen,
  output logic [127:0] core_block,
  input  logic         core_ready,
  input  logic         key_ready,
  input  logic [127:0] core_new_block
);

  state_t             state;
  state_t             state_nxt;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] grant;
  logic               grant_idx;
  logic               grant_owner;
  logic               enc_first;
  logic               key_accept;
  logic               accept;
  logic               enc_done;
  logic               rsp_done;
  block_t             result;

  assign req_valid  = {req1_valid, req0_valid};
  assign key_accept = (state == ST_IDLE) && key_init_req && reset_n;
  assign accept     = (state == ST_IDLE) && !key_init_req && key_loaded && (req_valid != '0);
  // The core still shows the previous ready in the cycle right after core_next.
  assign enc_done   = (state == ST_ENC_WAIT) && !enc_first && core_ready;
  assign rsp_done   = (state == ST_RESP) && (grant_owner ? rsp1_ready : rsp0_ready);

  aes_rr_arb2 u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (key_init_req) begin
          state_nxt = ST_KEY_START;
        end else if (accept) begin
          state_nxt = ST_ENC_START;
        end
      end
      ST_KEY_START: state_nxt = ST_KEY_WAIT;
      ST_KEY_WAIT:  if (key_ready) state_nxt = ST_IDLE;
      ST_ENC_START: state_nxt = ST_ENC_WAIT;
      ST_ENC_WAIT:  if (enc_done) state_nxt = ST_RESP;
      ST_RESP:      if (rsp_done) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    key_init_ack = key_accept;
    core_init    = (state == ST_KEY_START);
    core_next    = (state == ST_ENC_START);
    req0_ready   = accept && grant[0];
    req1_ready   = accept && grant[1];
    rsp0_valid   = (state == ST_RESP) && !grant_owner;
    rsp1_valid   = (state == ST_RESP) && grant_owner;
    rsp0_block   = result;
    rsp1_block   = result;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_loaded  <= 1'b0;
      core_keylen <= 1'b0;
      core_block  <= '0;
      grant_owner <= 1'b0;
      enc_first   <= 1'b0;
      result      <= '0;
    end else begin
      if (key_accept) begin
        core_keylen <= keylen;
      end
      if ((state == ST_KEY_WAIT) && key_ready) begin
        key_loaded <= 1'b1;
      end
      if (accept) begin
        core_block  <= grant_idx ? req1_block : req0_block;
        grant_owner <= grant_idx;
      end
      enc_first <= (state == ST_ENC_START);
      if (enc_done) begin
        result <= core_new_block;
      end
    end
  end

endmodule

// File: tb/tb_aes_enc_arbiter.sv
// tb/tb_aes_enc_arbiter.sv - self-checking bench for aes_enc_arbiter
module tb_aes_enc_arbiter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         key_init_req;
  logic         keylen;
  logic         key_init_ack;
  logic         key_loaded;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [127:0] req_block [2];
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [127:0] rsp_block [2];
  logic         core_init;
  logic         core_next;
  logic         core_keylen;
  logic [127:0] core_block;
  logic         core_ready;
  logic         key_ready;
  logic [127:0] core_new_block;

  int checks = 0;
  int errors = 0;
  int last_g = 1;

  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_enc_arbiter dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .key_init_req   (key_init_req),
    .keylen         (keylen),
    .key_init_ack   (key_init_ack),
    .key_loaded     (key_loaded),
    .req0_valid     (req_valid[0]),
    .req0_ready     (req_ready[0]),
    .req0_block     (req_block[0]),
    .req1_valid     (req_valid[1]),
    .req1_ready     (req_ready[1]),
    .req1_block     (req_block[1]),
    .rsp0_valid     (rsp_valid[0]),
    .rsp0_ready     (rsp_ready[0]),
    .rsp0_block     (rsp_block[0]),
    .rsp1_valid     (rsp_valid[1]),
    .rsp1_ready     (rsp_ready[1]),
    .rsp1_block     (rsp_block[1]),
    .core_init      (core_init),
    .core_next      (core_next),
    .core_keylen    (core_keylen),
    .core_block     (core_block),
    .core_ready     (core_ready),
    .key_ready      (key_ready),
    .core_new_block (core_new_block)
  );

  always #5 clk = ~clk;

  // Stand-in for the encipher core: the FIPS-197 vector for key 000102..0f, a fixed mix otherwise.
  function automatic logic [127:0] core_f(input logic [127:0] pt);
    if (pt == FIPS_PT) return FIPS_CT;
    return ~{pt[63:0], pt[127:64]};
  endfunction

  int           kcnt;
  int           ecnt;
  logic [127:0] ept;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_ready      <= 1'b1;
      kcnt           <= 0;
      core_ready     <= 1'b1;
      ecnt           <= 0;
      ept            <= '0;
      core_new_block <= '0;
    end else begin
      if (core_init) begin
        key_ready <= 1'b0;
        kcnt      <= 3;
      end else if (kcnt != 0) begin
        kcnt <= kcnt - 1;
        if (kcnt == 1) key_ready <= 1'b1;
      end
      // Ready stays stale for one cycle after core_next, like the real core.
      if (core_next) begin
        ecnt <= int'($urandom_range(1, 4));
        ept  <= core_block;
      end else if (ecnt != 0) begin
        ecnt <= ecnt - 1;
        if (ecnt == 1) begin
          core_ready     <= 1'b1;
          core_new_block <= core_f(ept);
        end else begin
          core_ready <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if ((core_init && core_next) || (rsp_valid == 2'b11)) begin
        errors++;
        $display("FAIL mon_exclusive core_init=%b core_next=%b rsp_valid=%b required no overlap",
                 core_init, core_next, rsp_valid);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic key_init(input logic kl);
    int n;
    keylen = kl;
    key_init_req = 1'b1;
    #1;
    n = 0;
    while (!key_init_ack && n < 100) begin @(negedge clk); n++; end
    chk("key_ack", key_init_ack, 1);
    chk("key_ack_no_ready", req_ready, 0);
    @(posedge clk); #1;
    key_init_req = 1'b0;
    chk("key_ack_pulse", key_init_ack, 0);
    chk("key_core_init", core_init, 1);
    @(posedge clk); #1;
    chk("key_core_init_pulse", core_init, 0);
    n = 0;
    while (!key_loaded && n < 100) begin @(negedge clk); n++; end
    chk("key_loaded", key_loaded, 1);
    chk("key_core_keylen", core_keylen, kl);
  endtask

  task automatic run_op(input int port, input logic [127:0] pt, input logic [127:0] exp,
                        input int hold, input bit raise_other);
    int n;
    int bad;
    req_block[port] = pt;
    req_valid[port] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[port] && n < 100) begin @(negedge clk); n++; end
    chk("op_accept", req_ready, 2'b1 << port);
    @(posedge clk); #1;
    req_valid[port] = 1'b0;
    last_g = port;
    @(negedge clk);
    chk("op_core_next_lat", core_next, 1);
    chk("op_core_block", core_block, pt);
    n = 0;
    while (rsp_valid == 2'b00 && n < 100) begin @(negedge clk); n++; end
    chk("op_rsp_valid", rsp_valid, 2'b1 << port);
    chk("op_rsp_block", rsp_block[port], exp);
    if (hold > 0) begin
      bad = 0;
      if (raise_other) begin
        req_block[1-port] = ~pt;
        req_valid[1-port] = 1'b1;
      end
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (rsp_valid !== (2'b1 << port) || rsp_block[port] !== exp || req_ready != 2'b00 || core_next)
          bad++;
      end
      chk("op_rsp_hold", bad, 0);
    end
    rsp_ready[port] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[port] = 1'b0;
    chk("op_rsp_drop", rsp_valid, 0);
  endtask

  typedef struct {
    int           port;
    logic [127:0] pt;
    logic [127:0] ct;
    int           hold;
  } vec_t;

  vec_t vt [4];

  initial begin
    int           n;
    int           bad;
    int           g;
    logic [127:0] blk;
    logic [127:0] blk2;
    logic [127:0] acc [2];
    bit           pend [2];
    logic [127:0] pblk [2];

    vt[0] = '{0, FIPS_PT, FIPS_CT, 0};
    vt[1] = '{1, 128'h0, {128{1'b1}}, 2};
    vt[2] = '{1, 128'hFFFFFFFFFFFFFFFF_0000000000000000, 128'hFFFFFFFFFFFFFFFF_0000000000000000, 0};
    vt[3] = '{0, 128'h00000000_00000001_00000000_00000002, 128'hFFFFFFFF_FFFFFFFD_FFFFFFFF_FFFFFFFE, 1};

    reset_n = 1'b0;
    key_init_req = 1'b0;
    keylen = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_block[0] = '0;
    req_block[1] = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {key_init_ack, key_loaded, req_ready, rsp_valid, core_init, core_next, core_keylen}, 0);
    chk("rst_core_block", core_block, 0);
    chk("rst_rsp_block", rsp_block[0], 0);
    reset_n = 1'b1;

    // Requests before any key load must be refused.
    req_block[0] = FIPS_PT;
    req_valid[0] = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (req_ready[0] || core_next) bad++;
    end
    chk("nokey_refused", bad, 0);
    req_valid[0] = 1'b0;

    key_init(1'b0);

    // Both requesters valid continuously: grants alternate starting with req0.
    acc[0] = {$urandom, $urandom, $urandom, $urandom};
    acc[1] = {$urandom, $urandom, $urandom, $urandom};
    req_block[0] = acc[0];
    req_block[1] = acc[1];
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      g = k % 2;
      n = 0;
      while (req_ready == 2'b00 && n < 100) begin @(negedge clk); n++; end
      chk("rr_grant", req_ready, 2'b1 << g);
      blk = acc[g];
      @(posedge clk); #1;
      acc[g] = {$urandom, $urandom, $urandom, $urandom};
      req_block[g] = acc[g];
      n = 0;
      while (rsp_valid == 2'b00 && n < 100) begin @(negedge clk); n++; end
      chk("rr_rsp_port", rsp_valid, 2'b1 << g);
      chk("rr_rsp_block", rsp_block[g], core_f(blk));
      rsp_ready[g] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[g] = 1'b0;
    end
    req_valid = 2'b00;
    last_g = 1;

    for (int i = 0; i < 4; i++)
      run_op(vt[i].port, vt[i].pt, vt[i].ct, vt[i].hold, 1'b0);

    // Response back-pressure with the other requester waiting.
    blk = {$urandom, $urandom, $urandom, $urandom};
    run_op(0, blk, core_f(blk), 10, 1'b1);
    run_op(1, ~blk, core_f(~blk), 0, 1'b0);

    // Key init raised mid-encryption waits for the response; block request waits behind it.
    blk = {$urandom, $urandom, $urandom, $urandom};
    blk2 = {$urandom, $urandom, $urandom, $urandom};
    req_block[0] = blk;
    req_valid[0] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[0] && n < 100) begin @(negedge clk); n++; end
    chk("k36_accept", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    key_init_req = 1'b1;
    keylen = 1'b1;
    req_block[1] = blk2;
    req_valid[1] = 1'b1;
    bad = 0;
    n = 0;
    while (!rsp_valid[0] && n < 100) begin
      if (key_init_ack || req_ready != 2'b00) bad++;
      @(negedge clk);
      n++;
    end
    if (key_init_ack || req_ready != 2'b00) bad++;
    chk("k36_no_ack_in_enc", bad, 0);
    chk("k36_rsp_block", rsp_block[0], core_f(blk));
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    chk("k36_ack_after_resp", key_init_ack, 1);
    chk("k36_req1_waits", req_ready, 0);
    @(posedge clk); #1;
    key_init_req = 1'b0;
    chk("k36_core_init", core_init, 1);
    run_op(1, blk2, core_f(blk2), 0, 1'b0);
    chk("k36_keylen", core_keylen, 1);

    // Randomized traffic against the round-robin / ordering model.
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int it = 0; it < 30; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 1) == 1) begin
          pend[p] = 1'b1;
          pblk[p] = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      if (!pend[0] && !pend[1]) begin
        pend[0] = 1'b1;
        pblk[0] = {$urandom, $urandom, $urandom, $urandom};
      end
      for (int p = 0; p < 2; p++) begin
        req_valid[p] = pend[p];
        req_block[p] = pblk[p];
      end
      #1;
      n = 0;
      while (req_ready == 2'b00 && n < 100) begin @(negedge clk); n++; end
      g = (pend[0] && pend[1]) ? 1 - last_g : (pend[0] ? 0 : 1);
      chk("rand_grant", req_ready, 2'b1 << g);
      @(posedge clk); #1;
      req_valid[g] = 1'b0;
      pend[g] = 1'b0;
      last_g = g;
      n = 0;
      while (rsp_valid == 2'b00 && n < 100) begin @(negedge clk); n++; end
      chk("rand_rsp_port", rsp_valid, 2'b1 << g);
      chk("rand_rsp_block", rsp_block[g], core_f(pblk[g]));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rsp_ready[g] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[g] = 1'b0;
    end
    req_valid = 2'b00;
    @(negedge clk);

    // Reset in the middle of an encryption abandons it.
    blk = {$urandom, $urandom, $urandom, $urandom};
    req_block[0] = blk;
    req_valid[0] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[0] && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("rst37_ctrl", {key_init_ack, key_loaded, req_ready, rsp_valid, core_init, core_next, core_keylen}, 0);
    chk("rst37_core_block", core_block, 0);
    chk("rst37_rsp_block", rsp_block[0], 0);
    @(negedge clk);
    reset_n = 1'b1;
    rsp_ready = 2'b11;
    req_valid[0] = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid != 2'b00 || core_next || req_ready != 2'b00 || key_loaded) bad++;
    end
    chk("rst37_silent", bad, 0);
    req_valid = 2'b00;
    rsp_ready = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
